// File: rtl/rr_pipe_sched_if.sv
// Producer/consumer bundle for rr_pipe_sched: per-source request/data/grant on one side,
// and the valid/ready output stream from pipeline stage B on the other.
interface rr_pipe_sched_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int SRC_W  = 2
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;
  logic                    busy;

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/rr_pipe_sched.sv
// Round-robin scheduler feeding a shared two-stage pipeline (A -> B) whose stage B
// presents a valid/ready stream downstream.
module rr_pipe_sched #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int SRC_W  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_pipe_sched_if.slave bus
);

  // Occupancy encoding is {a_v, b_v}, so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    HALF_B = 2'b01,
    HALF_A = 2'b10,
    FULL   = 2'b11
  } occ_e;

  occ_e              state_q, state_d;
  logic              a_v, b_v, advance;
  logic [DATA_W-1:0] a_data, b_data;
  logic [SRC_W-1:0]  a_src, b_src;
  logic [SRC_W-1:0]  ptr_q, ptr_inc;
  logic [SRC_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [N_REQ-1:0]  gnt_c;
  logic [SRC_W:0]    idx_w;

  assign a_v     = state_q[1];
  assign b_v     = state_q[0];
  assign advance = !b_v || bus.out_ready;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    gnt_c   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_w   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_w = {1'b0, ptr_q} + (SRC_W+1)'(i);
      if (idx_w >= (SRC_W+1)'(N_REQ))
        idx_w = idx_w - (SRC_W+1)'(N_REQ);
      if (!gnt_any && bus.req[idx_w[SRC_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w[SRC_W-1:0];
      end
    end
    // Reset is included so gnt stays low for the whole time rst_n is asserted.
    if (!(advance && rst_n))
      gnt_any = 1'b0;
    if (gnt_any)
      gnt_c[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_inc = gnt_idx + SRC_W'(1);
    if ({1'b0, gnt_idx} == (SRC_W+1)'(N_REQ - 1))
      ptr_inc = '0;
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      case (state_q)
        EMPTY:   state_d = gnt_any ? HALF_A : EMPTY;
        HALF_A:  state_d = gnt_any ? FULL   : HALF_B;
        HALF_B:  state_d = gnt_any ? HALF_A : EMPTY;
        FULL:    state_d = gnt_any ? FULL   : HALF_B;
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so stage B samples stage A's
  // old value on the same edge that stage A is reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      a_data <= '0;
      a_src  <= '0;
      b_data <= '0;
      b_src  <= '0;
    end else if (advance) begin
      b_data <= a_data;
      b_src  <= a_src;
      if (gnt_any) begin
        a_data <= bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        a_src  <= gnt_idx;
        ptr_q  <= ptr_inc;
      end
    end
  end

  assign bus.gnt       = gnt_c;
  assign bus.out_valid = b_v;
  assign bus.out_data  = b_data;
  assign bus.out_src   = b_src;
  assign bus.busy      = a_v || b_v;

endmodule

// File: tb/tb_rr_pipe_sched.sv
// Bench for rr_pipe_sched: hand-derived vector tables, reset corner cases and a
// randomized run checked against a delay-line/round-robin reference model.
module tb_rr_pipe_sched;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  rr_pipe_sched_if #(.N_REQ(N), .DATA_W(8), .SRC_W(2)) bus ();

  rr_pipe_sched #(.N_REQ(N), .DATA_W(8), .SRC_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a two-entry delay line (index 0 = newest) plus a scan pointer.
  typedef struct {
    bit         v;
    logic [7:0] d;
    int         s;
  } ent_t;

  ent_t       pipe[$];
  int         m_ptr;
  logic [3:0] last_gnt;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] data;
    bit          rdy;
    logic [3:0]  g;
    bit          v;
    logic [7:0]  d;
    int          s;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e.v = 0; e.d = '0; e.s = 0;
    m_ptr = 0;
    pipe.delete();
    pipe.push_back(e);
    pipe.push_back(e);
  endtask

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    int j;
    g = '0;
    if (!rst_n) return g;
    if (pipe[1].v && !bus.out_ready) return g;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (bus.req[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Compare current outputs with the model, then let one clock edge happen.
  task automatic step();
    logic [3:0] eg;
    ent_t       e;
    #1;
    eg = model_gnt();
    check("gnt", bus.gnt, eg);
    check("out_valid", bus.out_valid, pipe[1].v);
    check("busy", bus.busy, pipe[0].v | pipe[1].v);
    if (pipe[1].v) begin
      check("out_data", bus.out_data, pipe[1].d);
      check("out_src", bus.out_src, pipe[1].s);
    end
    last_gnt = eg;
    @(posedge clk);
    if (!pipe[1].v || bus.out_ready) begin
      e.v = 0; e.d = '0; e.s = 0;
      for (int i = 0; i < N; i++)
        if (eg[i]) begin
          e.v = 1;
          e.d = bus.req_data[i*8 +: 8];
          e.s = i;
          m_ptr = (i + 1) % N;
        end
      void'(pipe.pop_back());
      pipe.push_front(e);
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '1;
    bus.req_data = 32'h13121110;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_gnt", bus.gnt, 4'b0000);
      check("rst_valid", bus.out_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_data", bus.out_data, 8'h00);
      check("rst_src", bus.out_src, 2'd0);
    end
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input logic [31:0] data,
                     input bit rdy, input logic [3:0] g, input bit v,
                     input logic [7:0] d, input int s);
    vec_t x;
    x.rst = rst; x.req = req; x.data = data; x.rdy = rdy;
    x.g = g; x.v = v; x.d = d; x.s = s;
    vt.push_back(x);
  endtask

  bit          pend[N];
  logic [7:0]  pdat[N];
  int          wait_cnt[N];

  initial begin
    rst_n = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.out_ready = 1'b1;
    model_reset();

    // Rotation, all four sources requesting.
    add(1, 4'hF, 32'h13121110, 1, 4'b0001, 0, 8'h00, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b0010, 0, 8'h00, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h10, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b1000, 1, 8'h11, 1);
    add(0, 4'hF, 32'h13121110, 1, 4'b0001, 1, 8'h12, 2);
    add(0, 4'hF, 32'h13121110, 1, 4'b0010, 1, 8'h13, 3);
    add(0, 4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h10, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b1000, 1, 8'h11, 1);
    // Backpressure: five stalled cycles with FULL pipeline, then resume.
    add(1, 4'hF, 32'h13121110, 1, 4'b0001, 0, 8'h00, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b0010, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++)
      add(0, 4'hF, 32'h13121110, 0, 4'b0000, 1, 8'h10, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h10, 0);
    add(0, 4'hF, 32'h13121110, 1, 4'b1000, 1, 8'h11, 1);
    add(0, 4'hF, 32'h13121110, 1, 4'b0001, 1, 8'h12, 2);
    add(0, 4'hF, 32'h13121110, 1, 4'b0010, 1, 8'h13, 3);
    add(0, 4'hF, 32'h13121110, 1, 4'b0100, 1, 8'h10, 0);
    // Single transfer, then skip idle sources with pointer wrap from 3.
    add(1, 4'b0100, 32'h00A50000, 1, 4'b0100, 0, 8'h00, 0);
    add(0, 4'b0000, 32'h00A50000, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0000, 32'h00A50000, 1, 4'b0000, 1, 8'hA5, 2);
    add(0, 4'b0000, 32'h00A50000, 1, 4'b0000, 0, 8'h00, 0);
    add(0, 4'b0101, 32'h00220020, 1, 4'b0001, 0, 8'h00, 0);
    add(0, 4'b0101, 32'h00220020, 1, 4'b0100, 0, 8'h00, 0);
    add(0, 4'b0101, 32'h00220020, 1, 4'b0001, 1, 8'h20, 0);
    add(0, 4'b0000, 32'h00220020, 1, 4'b0000, 1, 8'h22, 2);
    add(0, 4'b0000, 32'h00220020, 1, 4'b0000, 1, 8'h20, 0);
    add(0, 4'b0000, 32'h00220020, 1, 4'b0000, 0, 8'h00, 0);

    // Reset and idle.
    do_reset();
    repeat (4) begin
      step();
      check("idle_data", bus.out_data, 8'h00);
    end

    foreach (vt[r]) begin
      if (vt[r].rst) do_reset();
      bus.req = vt[r].req;
      bus.req_data = vt[r].data;
      bus.out_ready = vt[r].rdy;
      #1;
      check("tbl_gnt", bus.gnt, vt[r].g);
      check("tbl_valid", bus.out_valid, vt[r].v);
      if (vt[r].v) begin
        check("tbl_data", bus.out_data, vt[r].d);
        check("tbl_src", bus.out_src, vt[r].s);
      end
      step();
    end

    // Asynchronous reset while FULL and stalled.
    do_reset();
    bus.req = 4'hF;
    bus.req_data = 32'h13121110;
    bus.out_ready = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_gnt", bus.gnt, 4'b0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("arst_first_gnt", bus.gnt, 4'b0001);
    step();

    // Randomized traffic: requests held until granted, random backpressure.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          pdat[i] = 8'($urandom);
          wait_cnt[i] = 0;
        end
      for (int i = 0; i < N; i++) begin
        bus.req[i] = pend[i];
        bus.req_data[i*8 +: 8] = pdat[i];
      end
      bus.out_ready = ($urandom_range(3) != 0);
      step();
      for (int i = 0; i < N; i++) begin
        if (last_gnt[i]) begin
          check("fairness", wait_cnt[i] <= N - 1, 1);
          pend[i] = 0;
        end else if (pend[i] && last_gnt != 4'b0000) begin
          wait_cnt[i]++;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
